// File: rtl/pht_access_sched_pkg.sv
// pht_access_sched_pkg: shared predictor widths, counter/FSM encodings and counter saturation.
package pht_access_sched_pkg;
    localparam int IDX_W_DEF = 14;
    localparam int CTR_W = 2;
    typedef enum logic [CTR_W-1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
    typedef enum logic {IDLE = 1'b0, UP_WR = 1'b1} state_e;
    function automatic logic [CTR_W-1:0] sat(input logic [CTR_W-1:0] c, input logic t);
        return t ? ((c == ST) ? c : c + 2'd1) : ((c == SNT) ? c : c - 2'd1);
    endfunction
endpackage

// File: rtl/pht_access_sched_upd_fifo.sv
// upd_fifo: synchronous FIFO of pending PHT updates with occupancy count.
module upd_fifo #(
    parameter int W = 15,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/pht_access_sched.sv
// pht_access_sched: shares the single PHT port between lookups and buffered
// read-modify-write counter updates; a full FIFO forces an update drain.
module pht_access_sched
    import pht_access_sched_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lk_valid,
    input  logic [IDX_W-1:0]       lk_idx,
    output logic                   lk_ready,
    output logic                   lk_rsp_valid,
    output logic [CTR_W-1:0]       lk_rsp_ctr,
    output logic                   lk_rsp_taken,
    input  logic                   up_valid,
    input  logic [IDX_W-1:0]       up_idx,
    input  logic                   up_taken,
    output logic                   up_ready,
    output logic                   tab_en,
    output logic                   tab_we,
    output logic [IDX_W-1:0]       tab_idx,
    output logic [CTR_W-1:0]       tab_wdata,
    input  logic [CTR_W-1:0]       tab_rdata,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_e state;
    logic [IDX_W-1:0] upd_idx_q;
    logic upd_tk_q;
    logic [IDX_W:0] head;
    logic full, idle, wr, lk_go, pop, push;
    // Reset gates the port and handshakes so they fall without waiting for an edge.
    assign full = fifo_cnt == CW'(DEPTH);
    assign idle = reset && state == IDLE;
    assign wr = reset && state == UP_WR;
    assign lk_go = idle && lk_valid && !full;
    assign pop = idle && !lk_go && fifo_cnt != '0;
    assign push = up_valid && up_ready;
    assign up_ready = reset && !full;
    assign lk_ready = lk_go;
    assign tab_en = lk_go || pop || wr;
    assign tab_we = wr;
    assign tab_idx = wr ? upd_idx_q : pop ? head[IDX_W:1] : lk_idx;
    assign tab_wdata = sat(tab_rdata, upd_tk_q);
    assign lk_rsp_ctr = tab_rdata;
    assign lk_rsp_taken = tab_rdata[1];
    assign busy = state == UP_WR || fifo_cnt != '0;
    upd_fifo #(.W(IDX_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .din({up_idx, up_taken}),
        .pop(pop),
        .dout(head),
        .cnt(fifo_cnt)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            lk_rsp_valid <= 1'b0;
            upd_idx_q <= '0;
            upd_tk_q <= 1'b0;
        end else begin
            lk_rsp_valid <= lk_go;
            state <= pop ? UP_WR : IDLE;
            if (pop) begin
                upd_idx_q <= head[IDX_W:1];
                upd_tk_q <= head[0];
            end
        end
    end
endmodule

// File: tb/tb_pht_access_sched.sv
// tb_pht_access_sched: scoreboard bench with a table model, directed scenarios and random traffic.
module tb_pht_access_sched;
    localparam int IDX_W = 14;
    localparam int DEPTH = 4;
    localparam int N = 1 << IDX_W;
    typedef struct {logic [IDX_W-1:0] idx; logic [1:0] d;} wr_t;
    logic clk = 1'b0, reset = 1'b0;
    logic lk_valid = 1'b0, up_valid = 1'b0, up_taken = 1'b0;
    logic [IDX_W-1:0] lk_idx = '0, up_idx = '0;
    logic lk_ready, lk_rsp_valid, lk_rsp_taken, up_ready, tab_en, tab_we, busy;
    logic [1:0] lk_rsp_ctr, tab_wdata, tab_rdata;
    logic [IDX_W-1:0] tab_idx;
    logic [$clog2(DEPTH):0] fifo_cnt;
    int vectors = 0, errs = 0;
    logic [1:0] mem [N];
    logic [1:0] applied [N];
    logic [1:0] model_tab [N];
    bit mem_init = 0;
    wr_t exp_wr[$];
    logic [1:0] exp_lk[$];
    wr_t wlog[$];
    always #5 clk = ~clk;
    pht_access_sched #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_ready(lk_ready),
        .lk_rsp_valid(lk_rsp_valid), .lk_rsp_ctr(lk_rsp_ctr), .lk_rsp_taken(lk_rsp_taken),
        .up_valid(up_valid), .up_idx(up_idx), .up_taken(up_taken), .up_ready(up_ready),
        .tab_en(tab_en), .tab_we(tab_we), .tab_idx(tab_idx), .tab_wdata(tab_wdata),
        .tab_rdata(tab_rdata), .fifo_cnt(fifo_cnt), .busy(busy)
    );
    function automatic logic [1:0] init_val(input int i);
        if (i == 'h123) return 2'b10;
        if (i == 5 || i == 6) return 2'b01;
        if (i == 'h3FFF) return 2'b00;
        return 2'((i ^ (i >> 4)) & 3);
    endfunction
    function automatic logic [1:0] sat_ref(input logic [1:0] c, input logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    // Synchronous single-port table: read data one cycle after a read enable.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < N; i++) mem[i] <= init_val(i);
            mem_init <= 1;
        end else begin
            if (tab_en && !tab_we) tab_rdata <= mem[tab_idx];
            if (tab_en && tab_we) mem[tab_idx] <= tab_wdata;
        end
    end
    // Issue side: record accepted lookups and updates with their expected results.
    initial begin
        for (int i = 0; i < N; i++) model_tab[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!reset) begin
                foreach (exp_wr[k]) model_tab[exp_wr[k].idx] = applied[exp_wr[k].idx];
                exp_wr.delete();
                exp_lk.delete();
            end else begin
                if (lk_ready) begin
                    chk("lk_port", 32'({tab_en, tab_we, tab_idx}), 32'({2'b10, lk_idx}));
                    exp_lk.push_back(applied[lk_idx]);
                end
                if (up_valid && up_ready) begin
                    logic [1:0] nv;
                    nv = sat_ref(model_tab[up_idx], up_taken);
                    model_tab[up_idx] = nv;
                    exp_wr.push_back('{up_idx, nv});
                end
            end
        end
    end
    // Monitor: compare responses and table writes against the expected queues.
    initial begin
        logic prev_rd;
        logic [IDX_W-1:0] prev_idx;
        prev_rd = 0;
        prev_idx = '0;
        for (int i = 0; i < N; i++) applied[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (reset) begin
                if (lk_rsp_valid) begin
                    if (exp_lk.size() == 0) chk("lk_unexpected", 32'(1), 32'(0));
                    else begin
                        logic [1:0] e;
                        e = exp_lk.pop_front();
                        chk("lk_rsp_ctr", 32'(lk_rsp_ctr), 32'(e));
                        chk("lk_rsp_taken", 32'(lk_rsp_taken), 32'(e[1]));
                    end
                end
                if (tab_en && tab_we) begin
                    chk("wr_after_rd", 32'(prev_rd && prev_idx == tab_idx), 32'(1));
                    if (exp_wr.size() == 0) chk("wr_unexpected", 32'(1), 32'(0));
                    else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        chk("wr_idx", 32'(tab_idx), 32'(e.idx));
                        chk("wr_data", 32'(tab_wdata), 32'(e.d));
                        applied[e.idx] = e.d;
                    end
                    wlog.push_back('{tab_idx, tab_wdata});
                end
                prev_rd = tab_en && !tab_we && !lk_ready;
                prev_idx = tab_idx;
            end else prev_rd = 0;
        end
    end
    task automatic push(input logic [IDX_W-1:0] idx, input logic tk);
        up_valid = 1;
        up_idx = idx;
        up_taken = tk;
        @(posedge clk);
        #1 up_valid = 0;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        chk("idle_timeout", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
    endtask
    task automatic chk_log(input string n, input logic [IDX_W-1:0] i0, input logic [IDX_W-1:0] i1,
                           input logic [IDX_W-1:0] i2, input logic [1:0] d0, input logic [1:0] d1,
                           input logic [1:0] d2, input int cnt);
        logic [IDX_W-1:0] ei [3];
        logic [1:0] ed [3];
        ei = '{i0, i1, i2};
        ed = '{d0, d1, d2};
        chk({n, "_count"}, 32'(wlog.size()), 32'(cnt));
        for (int k = 0; k < cnt && k < wlog.size(); k++) begin
            chk({n, "_idx"}, 32'(wlog[k].idx), 32'(ei[k]));
            chk({n, "_data"}, 32'(wlog[k].d), 32'(ed[k]));
        end
        wlog.delete();
    endtask
    initial begin
        lk_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tab_en", 32'(tab_en), 32'(0));
        chk("rst_tab_we", 32'(tab_we), 32'(0));
        chk("rst_lk_ready", 32'(lk_ready), 32'(0));
        chk("rst_up_ready", 32'(up_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rsp_valid", 32'(lk_rsp_valid), 32'(0));
        chk("rst_fifo_cnt", 32'(fifo_cnt), 32'(0));
        lk_valid = 0;
        @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("up_ready_after_rst", 32'(up_ready), 32'(1));
        @(posedge clk);
        #1 lk_valid = 1;
        lk_idx = 14'h0123;
        @(negedge clk);
        chk("lk_ready", 32'(lk_ready), 32'(1));
        @(posedge clk);
        #1 lk_valid = 0;
        @(negedge clk);
        chk("lk_rsp_valid", 32'(lk_rsp_valid), 32'(1));
        chk("lk_0123_ctr", 32'(lk_rsp_ctr), 32'(2));
        chk("lk_0123_taken", 32'(lk_rsp_taken), 32'(1));
        @(posedge clk);
        #1 wlog.delete();
        repeat (3) push(14'h0005, 1);
        wait_idle();
        chk_log("sat_tk", 5, 5, 5, 2'b10, 2'b11, 2'b11, 3);
        repeat (3) push(14'h0006, 0);
        wait_idle();
        chk_log("sat_nt", 6, 6, 6, 2'b00, 2'b00, 2'b00, 3);
        lk_valid = 1;
        lk_idx = 14'h0010;
        for (int i = 0; i < 4; i++) begin
            up_valid = 1;
            up_idx = 14'(32'h20 + i);
            up_taken = 1'(i);
            @(posedge clk);
            #1;
        end
        up_valid = 0;
        @(negedge clk);
        chk("drain_cnt", 32'(fifo_cnt), 32'(4));
        chk("drain_up_ready", 32'(up_ready), 32'(0));
        chk("drain_lk_ready", 32'(lk_ready), 32'(0));
        chk("drain_pop_rd", 32'({tab_en, tab_we, tab_idx}), 32'({2'b10, 14'h20}));
        @(negedge clk);
        chk("drain_wr", 32'(tab_we), 32'(1));
        chk("drain_wr_lk_ready", 32'(lk_ready), 32'(0));
        @(negedge clk);
        chk("drain_lk_back", 32'(lk_ready), 32'(1));
        @(posedge clk);
        #1 lk_valid = 0;
        wait_idle();
        wlog.delete();
        lk_valid = 1;
        lk_idx = 14'h0040;
        push(14'h0030, 1);
        push(14'h0031, 0);
        lk_valid = 0;
        up_valid = 1;
        up_idx = 14'h0032;
        up_taken = 1;
        @(negedge clk);
        chk("pp_cnt_before", 32'(fifo_cnt), 32'(2));
        chk("pp_pop_idx", 32'({tab_en, tab_we, tab_idx}), 32'({2'b10, 14'h30}));
        @(posedge clk);
        #1 up_valid = 0;
        @(negedge clk);
        chk("pp_cnt_after", 32'(fifo_cnt), 32'(2));
        wait_idle();
        chk_log("pp_order", 14'h30, 14'h31, 14'h32,
                sat_ref(init_val('h30), 1), sat_ref(init_val('h31), 0), sat_ref(init_val('h32), 1), 3);
        push(14'h0050, 1);
        @(posedge clk);
        #1 chk("rmw_we_before_rst", 32'(tab_we), 32'(1));
        reset = 0;
        #1 chk("rmw_we_async_drop", 32'(tab_we), 32'(0));
        chk("rmw_en_async_drop", 32'(tab_en), 32'(0));
        @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("post_rst_cnt", 32'(fifo_cnt), 32'(0));
        chk("post_rst_busy", 32'(busy), 32'(0));
        chk("post_rst_nowrite", 32'(wlog.size()), 32'(0));
        @(posedge clk);
        #1 lk_valid = 1;
        lk_idx = 14'h0050;
        @(posedge clk);
        #1 lk_valid = 0;
        @(negedge clk);
        chk("abort_tab_kept", 32'(lk_rsp_ctr), 32'(init_val('h50)));
        @(posedge clk);
        #1 wlog.delete();
        push(14'h3FFF, 1);
        push(14'h3FFF, 1);
        wait_idle();
        chk_log("b2b", 14'h3FFF, 14'h3FFF, 0, 2'b01, 2'b10, 2'b00, 2);
        begin
            logic la, ua;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                la = lk_ready;
                ua = up_valid && up_ready;
                @(posedge clk);
                #1;
                if (!lk_valid || la) begin
                    lk_valid = ($urandom % 2) == 0;
                    lk_idx = 14'($urandom_range(0, 7)) | 14'h0200;
                end
                if (!up_valid || ua) begin
                    up_valid = ($urandom % 5) < 2;
                    up_idx = 14'($urandom_range(0, 7)) | 14'h0200;
                    up_taken = 1'($urandom);
                end
            end
            @(negedge clk);
            ua = up_valid && up_ready;
            while (up_valid && !ua) begin
                @(negedge clk);
                ua = up_valid && up_ready;
            end
            @(posedge clk);
            #1 up_valid = 0;
            lk_valid = 0;
        end
        wait_idle();
        chk("end_exp_wr_empty", 32'(exp_wr.size()), 32'(0));
        chk("end_exp_lk_empty", 32'(exp_lk.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
